// File: rtl/result_display_pkg.sv
// Shared definitions for the result_display formatter: FSM states,
// seven-segment codes (active-low, gfedcba with bit0 = a) and sizing.
package result_display_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } state_t;

  // Number of displayed digits and the BCD scratch (one spare nibble
  // so an out-of-range magnitude is still detectable)
  localparam int DIGITS      = 6;
  localparam int SCR_NIBBLES = DIGITS + 1;
  localparam int SCR_W       = 4 * SCR_NIBBLES;

  // Segment patterns
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/result_display_seg7_encode.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Non-decimal codes produce a blank digit.
module seg7_encode
  import result_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Digit lookup
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_DIGIT[0];
      4'd1: seg = SEG_DIGIT[1];
      4'd2: seg = SEG_DIGIT[2];
      4'd3: seg = SEG_DIGIT[3];
      4'd4: seg = SEG_DIGIT[4];
      4'd5: seg = SEG_DIGIT[5];
      4'd6: seg = SEG_DIGIT[6];
      4'd7: seg = SEG_DIGIT[7];
      4'd8: seg = SEG_DIGIT[8];
      4'd9: seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display.sv
// Serial double-dabble formatter for the ALU result: captures a value,
// converts its magnitude to BCD over WIDTH shift cycles, then registers
// BCD, sign/overflow flags and blanked seven-segment patterns.
module result_display #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  is_signed,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);
  import result_display_pkg::*;

  localparam int SCR_N = DIGITS + 1;
  localparam int SCR_B = 4 * SCR_N;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [WIDTH-1:0]     mag_reg;
  logic [SCR_B-1:0]     scr_reg;
  logic                 neg_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [4*DIGITS-1:0]  bcd_reg;
  logic                 negative_reg;
  logic                 overflow_reg;
  logic [7*DIGITS-1:0]  hex_reg;

  logic [SCR_B-1:0]     scr_adj;
  logic [SCR_B-1:0]     scr_next;
  logic [WIDTH-1:0]     mag_next;
  logic [DIGITS:0]      nz_up;
  logic                 fmt_ovf;
  logic [7*DIGITS-1:0]  hex_fmt;
  logic [6:0]           seg_out [DIGITS];

  genvar gi;

  // Add-3 correction on every scratch nibble that would overflow when doubled
  for (gi = 0; gi < SCR_N; gi++) begin : g_adj
    assign scr_adj[4*gi +: 4] = (scr_reg[4*gi +: 4] >= 4'd5) ?
                                scr_reg[4*gi +: 4] + 4'd3 : scr_reg[4*gi +: 4];
  end

  assign scr_next = {scr_adj[SCR_B-2:0], mag_reg[WIDTH-1]};
  assign mag_next = {mag_reg[WIDTH-2:0], 1'b0};

  // nz_up[k]: some displayed digit at position k or above is nonzero
  assign nz_up[DIGITS] = 1'b0;
  for (gi = 0; gi < DIGITS; gi++) begin : g_nz
    assign nz_up[gi] = nz_up[gi+1] | (scr_reg[4*gi +: 4] != 4'd0);
  end

  // A negative value needs one extra digit position for the minus sign
  assign fmt_ovf = (scr_reg[4*DIGITS +: 4] != 4'd0) |
                   (neg_reg & (scr_reg[4*(DIGITS-1) +: 4] != 4'd0));

  // Per-digit encode plus blank/minus/E override
  for (gi = 0; gi < DIGITS; gi++) begin : g_hex
    seg7_encode u_enc (
      .digit (scr_reg[4*gi +: 4]),
      .seg   (seg_out[gi])
    );
    if (gi == 0) begin : g_ones
      assign hex_fmt[6:0] = fmt_ovf ? SEG_E : seg_out[0];
    end else begin : g_upper
      assign hex_fmt[7*gi +: 7] = fmt_ovf              ? SEG_BLANK   :
                                  nz_up[gi]            ? seg_out[gi] :
                                  (neg_reg & nz_up[gi-1]) ? SEG_MINUS :
                                  SEG_BLANK;
    end
  end

  // Sequencer, shift engine and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      mag_reg      <= '0;
      scr_reg      <= '0;
      neg_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bcd_reg      <= '0;
      negative_reg <= 1'b0;
      overflow_reg <= 1'b0;
      hex_reg      <= {DIGITS{SEG_BLANK}};
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mag_reg   <= (is_signed && value[WIDTH-1]) ? -value : value;
            neg_reg   <= is_signed & value[WIDTH-1];
            scr_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scr_reg <= scr_next;
          mag_reg <= mag_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_FORMAT;
          end
        end
        ST_FORMAT: begin
          bcd_reg      <= scr_reg[4*DIGITS-1:0];
          negative_reg <= neg_reg;
          overflow_reg <= fmt_ovf;
          hex_reg      <= hex_fmt;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign bcd      = bcd_reg;
  assign negative = negative_reg;
  assign overflow = overflow_reg;
  assign hex      = hex_reg;

endmodule

// File: doc/result_display.md
# result_display

Sequential formatter that sits directly downstream of the mini ALU. It captures the ALU's 20-bit `result`, converts it to six BCD digits with a serial double-dabble (shift-add-3) engine, and drives six active-low seven-segment digits. The display applies leading-zero blanking, a minus sign and an overflow indication. A start/busy/done handshake lets the board top-level trigger a conversion whenever the operands or operation change.

## Interface

- `WIDTH`, default 20: input value width; the iteration count equals `WIDTH`.
- `DIGITS`, default 6: number of displayed digits.
- `clk`  input  1  single system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request conversion; sampled only while `busy`=0.
- `value`  input  20  ALU result to convert; sampled with `start`.
- `is_signed`  input  1  1: treat `value` as two's complement (ALU subtraction); 0: unsigned.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  one-cycle pulse when outputs update.
- `bcd`  output  24  six BCD nibbles of the magnitude; `bcd[3:0]` is the ones digit.
- `negative`  output  1  the converted value was negative.
- `overflow`  output  1  the result does not fit on `DIGITS` digits.
- `hex`  output  42  segment patterns; `hex[7k+6:7k]` drives digit k (0 is rightmost).
  - Active-low.
  - Bit order gfedcba, with bit0 = a.

## Operation

**IDLE**
- On an edge with `start`=1, latch `value` and `is_signed`.
- Magnitude: if `is_signed` and `value[19]`, magnitude = −`value` (20-bit negate) and set the internal neg flag. 20'h80000 yields 524288, which fits unsigned.
- Clear the 28-bit (7-nibble) BCD scratch and the iteration counter; go to SHIFT.

**SHIFT**
- Each cycle: add 3 to every scratch nibble ≥5, then shift {scratch, magnitude} left by one.
- After the 20th shift, go to FORMAT.

**FORMAT** (one cycle; register all outputs, pulse `done`, return to IDLE)
- `overflow` = (nibble 6 ≠ 0) or (neg and nibble 5 ≠ 0).
- `bcd` = scratch nibbles 5..0.
- `negative` = neg.

**Display rules** (non-overflow)
- Digit 0 is always lit.
- Digits above the most significant nonzero digit are blank.
- With neg set, the minus sign sits in the digit immediately left of the most significant nonzero digit.
- Overflow display: digit 0 = E, all other digits blank.

**Segment codes**
- Digits: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
- Symbols: minus=7'h3F, E=7'h06, blank=7'h7F.

**Handshake and boundary behaviour**
- `start` while `busy`=1 is ignored.
- `start` in the cycle `done`=1 is accepted, because the state is already IDLE.
- `bcd`, `negative`, `overflow` and `hex` hold their values until the next FORMAT.
- `value` and `is_signed` may change freely after the sampling edge.
- `rst_n` low at any time aborts the conversion immediately.

## Timing

- **Reset values:**
  - State IDLE; `busy`=0, `done`=0.
  - `bcd`=0, `negative`=0, `overflow`=0.
  - `hex` all 7'h7F (blank).
- **Edge numbering:** the start-sampling edge is edge 0.
  - `busy` rises after edge 0.
  - Shifts occur on edges 1–20.
  - FORMAT executes on edge 21.
- **Outputs:** they update and `done`=1 during the cycle after edge 21. `busy` falls at that same edge.
- **Latency:** 21 cycles, start to done, for every value.
- **Throughput:** one conversion per 22 cycles.
- **Path depth:** no combinational path from inputs to outputs; every output is registered.

## Structure

- `result_display_pkg`:
  - State enum (IDLE, SHIFT, FORMAT).
  - Segment constants: `SEG_DIGIT[0:9]`, `SEG_MINUS`, `SEG_E`, `SEG_BLANK`.
  - `DIGITS` and the BCD scratch width (7 nibbles).
- Sub-module `seg7_encode`: combinational 4-bit BCD → 7-bit active-low pattern. It is instantiated once per digit in the FORMAT output path; the blank/minus/E override muxing stays in the parent.

## Test plan

- Unsigned 20'd30 (15+15):
  - `done` exactly 21 cycles after the start edge.
  - `bcd`=24'h000030.
  - hex0=7'h40, hex1=7'h30, digits 2–5 = 7'h7F.
- Signed 20'hFFFFE (3−5):
  - `negative`=1, `bcd`=24'h000002.
  - hex0=7'h24, hex1=7'h3F, others blank.
- Unsigned 20'd491520 (15<<<15):
  - `bcd`=24'h491520, `overflow`=0.
  - All six digits lit, no blanking.
- Overflow cases:
  - Unsigned 20'hFFFFF gives `overflow`=1, `bcd`=24'h048575, hex0=7'h06, others blank.
  - Signed 20'h80000 gives `negative`=1 and `overflow`=1.
- Unsigned 0:
  - `bcd`=0; hex0=7'h40, others blank.
  - `start` pulses during `busy` cause no restart, and `done` still arrives at cycle 21.
- `rst_n` low at cycle 10 of a conversion:
  - `busy`=0 immediately and all outputs return to reset values.
  - No `done` pulse.
  - A subsequent start converts normally.
